// File: rtl/varshift_tx.sv
// varshift_tx: N-bit parallel-to-serial shifter, MSB first, 0-3 bits/cycle.
// Optional: define VARSHIFT_TX_UNDERRUN_EN to add a sticky underrun output.
module varshift_tx #(
    parameter int N = 8,
    localparam int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [N-1:0]  load_data,
    input  logic [1:0]    sh_amount,
    output logic [2:0]    sout,
    output logic [1:0]    sout_cnt,
    output logic          sout_valid,
    output logic          sout_last,
`ifdef VARSHIFT_TX_UNDERRUN_EN
    output logic          underrun,
`endif
    output logic [LW-1:0] level
);

    localparam int CW = (LW > 2) ? LW : 2;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [N-1:0]  shreg;
    logic [CW-1:0] k_ext;
    logic [CW-1:0] lvl_ext;
    logic [CW-1:0] g_ext;
    logic [1:0]    g;
    logic [N+2:0]  ext;
    logic [2:0]    top3;
    logic [2:0]    mask;
    logic [2:0]    bits;

    assign state      = (level == '0) ? IDLE : BUSY;
    assign load_ready = (state == IDLE);

    // Grant is the request clipped to the bits still held; the
    // zero-padded extension keeps the top-3 slice legal when N < 3.
    always_comb begin
        k_ext   = CW'(sh_amount);
        lvl_ext = CW'(level);
        g_ext   = (k_ext > lvl_ext) ? lvl_ext : k_ext;
        g       = g_ext[1:0];
        ext     = {shreg, 3'b000};
        top3    = ext[N+2:N];
        mask    = 3'b000;
        case (g)
            2'd1:    mask = 3'b100;
            2'd2:    mask = 3'b110;
            2'd3:    mask = 3'b111;
            default: mask = 3'b000;
        endcase
        bits = top3 & mask;
    end

    // Load in IDLE, shift out the granted bits in BUSY; outputs are
    // one-cycle pulses that fall back to zero without a new grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg      <= '0;
            level      <= '0;
            sout       <= '0;
            sout_cnt   <= '0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
        end else begin
            sout       <= '0;
            sout_cnt   <= '0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shreg <= load_data;
                        level <= LW'(N);
                    end
                end
                BUSY: begin
                    sout       <= bits;
                    sout_cnt   <= g;
                    sout_valid <= (g != 2'd0);
                    sout_last  <= (g != 2'd0) && (g_ext == lvl_ext);
                    shreg      <= shreg << g;
                    level      <= level - LW'(g_ext);
                end
                default: begin
                    level <= '0;
                end
            endcase
        end
    end

`ifdef VARSHIFT_TX_UNDERRUN_EN
    // Sticky flag for requests larger than what is held; an accepted
    // load clears it even if that same cycle over-requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun <= 1'b0;
        end else if (load_valid && load_ready) begin
            underrun <= 1'b0;
        end else if (k_ext > lvl_ext) begin
            underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/varshift_tx.md
Name: varshift_tx

Overview:
- Parallel-to-serial counterpart of the team's variable-width shift-register receiver.
- Accepts an N-bit word through a valid/ready load handshake.
- Emits the word MSB-first, 0–3 bits per cycle, in the amount requested by the consumer each cycle.
- Output bits are MSB-aligned in a 3-bit field, so sout/sout_cnt feed the receiver's sin/sh_amount directly.

Parameters:
- N, 8, word width in bits; N >= 1.
- LW, $clog2(N+1), width of the remaining-bit counter (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; one clock, no other reset.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  combinational; high when level == 0.
- load_data  input  N  word to serialize.
- sh_amount  input  2  bits requested this cycle (0–3).
- sout  output  3  emitted bits, MSB-aligned: sout[2] is the first bit; unused low bits are 0.
- sout_cnt  output  2  number of valid bits in sout (0–3).
- sout_valid  output  1  high when sout_cnt != 0.
- sout_last  output  1  high with the emission that drains the word.
- level  output  LW  bits still held, not yet emitted.

Behaviour:
- State: shreg[N-1:0], level.
- Two states, derived from level:
  - IDLE: level == 0.
  - BUSY: level > 0.
- Reset (rst low, asynchronous): shreg=0, level=0, sout=0, sout_cnt=0, sout_valid=0, sout_last=0. load_ready=1 as soon as rst is low.
- IDLE:
  - load_valid && load_ready at an edge: shreg<=load_data, level<=N, go BUSY.
  - sh_amount is ignored; the registered outputs show sout=0, cnt=0, valid=0, last=0.
- BUSY, each edge, with k=sh_amount, g=min(k,level):
  - sout <= top g bits of shreg placed at sout[2:3-g], rest 0.
  - sout_cnt <= g; sout_valid <= (g!=0); sout_last <= (g!=0 && g==level).
  - shreg <= shreg << g (zero fill); level <= level - g.
  - load_ready is low, so load_valid is ignored.
- Latency: bits requested in cycle t appear on sout in cycle t+1.
  - sout/cnt/valid/last are registered and hold for exactly one cycle.
  - They return to 0 on the next edge unless a new grant occurs.
- k=0 in BUSY: no change to shreg or level; outputs go to 0.
- Short grant: k > level gives a short final grant (g=level); the excess is dropped. No wrap, no refill from a pending load.
- Drain then load: the cycle after level reaches 0, load_ready=1. The fastest load-to-load spacing is ceil(N/3)+1 cycles.
- Reset while BUSY discards the word immediately; no partial output.
- N < 3: g is still limited by level; the shift never exceeds N.

Optional Feature:
- Macro VARSHIFT_TX_UNDERRUN_EN.
- Defined:
  - Adds output port underrun (1 bit), reset 0.
  - Sets sticky at the edge where k > level, in either IDLE or BUSY.
  - Cleared only by an accepted load or by rst.
- Undefined:
  - Port absent.
  - Short requests are silently truncated as described in Behaviour.
- Data path behaviour is identical in both builds.

Test Plan:
- Reset, then load 8'hB5 (N=8); request 3,2,3 on successive cycles -> sout/cnt = 3'b101/3, 3'b100/2, 3'b101/3. last=1 only on the third; level 8→5→3→0; load_ready=1 the next cycle.
- Load 8'hB5; request 3,3,3 -> third output is sout=3'b010, cnt=2, last=1. With VARSHIFT_TX_UNDERRUN_EN, underrun=1 and stays set until the next accepted load.
- Load 8'hF0; request 0 for 4 cycles, then 1 -> valid=0 and level=8 throughout the zero requests; then sout=3'b100, cnt=1, level=7.
- Load 8'hA5; reset asserted asynchronously mid-word after one 3-bit grant -> all outputs 0 immediately, level=0, load_ready=1. The next load of 8'h3C serializes correctly from the MSB.
- Loopback: connect sout→sin and sout_cnt→sh_amount of the 8-bit receiver. Load random words with random sh_amount sequences, 1000 words -> receiver out equals each loaded word on the cycle after its sout_last.
- load_valid held high while BUSY with changing load_data -> no corruption; only the value present when load_ready=1 is captured.
